product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
// PURPOSE
//  Downstream stage of the CSA parallel multiplier. Consumes registered products as a stream of
//  valid/ready beats, sums each frame (terminated by in_last) into a wide accumulator, and
//  presents the frame total on a held valid/ready output until the consumer accepts it.
//  Provides multiply-accumulate (dot-product) capability without widening the multiplier.
// PARAMETERS
//  SIZE     16          multiplier operand width; product width is 2*SIZE
//  GUARD    8           accumulator guard bits above the product width
//  ACC_W    2*SIZE+GUARD accumulator and result width (derived, do not override)
//  CNT_W    8           beat-counter width
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  clear        in   1       synchronous abort: discard frame and pending result
//  in_valid     in   1       in_prod/in_last valid
//  in_ready     out  1       stage can accept a beat this cycle
//  in_prod      in   2*SIZE  unsigned product from the multiplier
//  in_last      in   1       beat closes the current frame
//  out_valid    out  1       out_acc/out_count/out_overflow valid
//  out_ready    in   1       consumer accepts the result
//  out_acc      out  ACC_W   frame sum
//  out_count    out  CNT_W   beats in frame, saturating at 2^CNT_W-1
//  out_overflow out  1       sticky: sum exceeded ACC_W bits during frame
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; acc, count, overflow, out_acc, out_count = 0; out_valid=0.
//  - FSM states: IDLE (no beats in frame), ACCUM (>=1 beat taken), HOLD (result presented).
//  - in_ready = (state != HOLD) && !clear. A beat is taken when in_valid && in_ready.
//  - Beat without in_last: acc <= acc + in_prod (zero-extended); count += 1; IDLE->ACCUM.
//  - Beat with in_last (from IDLE or ACCUM): out_acc <= acc + in_prod; out_count <= count+1;
//    out_overflow <= overflow | carry; out_valid=1 the next cycle; state->HOLD; acc, count,
//    overflow cleared. A single-beat frame is legal (out_count=1).
//  - Latency: last beat accepted at edge N -> out_valid high after edge N (visible cycle N+1).
//  - HOLD: outputs stable while out_valid && !out_ready. out_valid && out_ready -> IDLE with
//    out_valid=0; in_ready rises the cycle after the handshake (no same-cycle bypass).
//  - Overflow: carry out of bit ACC_W-1 sets the sticky flag; arithmetic per CONFIGURATION.
//  - Count saturates at all-ones; it never wraps.
//  - clear: highest priority, any state. Next state IDLE; acc/count/overflow=0; out_valid=0
//    (a pending result is dropped); any simultaneous input beat is not taken (in_ready=0).
//  - rst_n asserted mid-frame or in HOLD: all state is lost immediately; no partial output.
//  - Outputs are registered; in_ready is combinational from state and clear only.
// CONFIGURATION
//  - MULT_ACC_SATURATE_EN defined: on overflow acc clamps to all-ones and stays there for the
//    rest of the frame; out_acc = 2^ACC_W-1.
//  - Not defined: acc wraps modulo 2^ACC_W. out_overflow behaves identically in both builds.
// STRUCTURE
//  - Package mult_acc_pkg: state enum {IDLE, ACCUM, HOLD}, default SIZE/GUARD/CNT_W constants,
//    ACC_W derivation function.
//  - One sub-module acc_adder: ACC_W add of acc and zero-extended product, returns sum and carry,
//    applies clamp under MULT_ACC_SATURATE_EN. FSM, counters and output registers stay in the top.
// TESTING (SIZE=16, GUARD=8, CNT_W=8)
//  - Frame 0x0006, 0x000C, last 0x0014 with out_ready=1 -> out_acc=0x26, out_count=3,
//    overflow=0, out_valid one cycle after the last beat.
//  - Single beat 0xFFFE0001 last, out_ready low for 5 cycles -> outputs held, in_ready=0
//    throughout; in_ready=1 the cycle after the handshake.
//  - 257 beats of 0xFFFFFFFF, last on beat 257 -> out_count=0xFF, out_overflow=1;
//    out_acc=0xFF_FFFF_FFFF with MULT_ACC_SATURATE_EN, 0x00_FFFF_FEFF without.
//  - clear asserted with in_valid on beat 2 of a frame -> beat dropped, next frame 0x5 last
//    -> out_acc=0x5, out_count=1.
//  - clear while in HOLD -> out_valid drops the next cycle, result never handshaken.
//  - rst_n pulsed low mid-frame (async, between edges) -> out_valid=0, acc=0 immediately;
//    the following frame sums from zero.

Source files
------------

// File: rtl/mult_acc_pkg.sv
// Shared types and constants for the product accumulator stage.
package mult_acc_pkg;

  localparam int SIZE_DEF  = 16;
  localparam int GUARD_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic int acc_width(input int size, input int guard);
    return 2 * size + guard;
  endfunction

endpackage

// File: rtl/acc_adder.sv
// Accumulator adder: acc + zero-extended product with carry out of the top bit.
// With MULT_ACC_SATURATE_EN defined the sum clamps to all-ones on carry; otherwise it wraps.
module acc_adder #(
  parameter int ACC_W  = 40,
  parameter int PROD_W = 32
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] raw;

  assign raw   = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
  assign carry = raw[ACC_W];

`ifdef MULT_ACC_SATURATE_EN
  assign sum = carry ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
  assign sum = raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums framed product beats into a wide accumulator and holds each frame total until accepted.
// Optional clamp-on-overflow arithmetic is selected with MULT_ACC_SATURATE_EN (see acc_adder).
module product_accumulator
  import mult_acc_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int GUARD = GUARD_DEF,
  parameter int ACC_W = acc_width(SIZE, GUARD),
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*SIZE-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and out_* stay stable while out_valid && !out_ready.

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic [CNT_W-1:0] cnt_inc;
  logic             take;

  assign in_ready = (state != HOLD) && !clear;
  assign take     = in_valid && in_ready;
  assign cnt_inc  = (count == {CNT_W{1'b1}}) ? count : count + 1'b1;

  acc_adder #(
    .ACC_W  (ACC_W),
    .PROD_W (2 * SIZE)
  ) u_adder (
    .acc   (acc),
    .prod  (in_prod),
    .sum   (sum),
    .carry (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, ACCUM: if (take) state_next = in_last ? HOLD : ACCUM;
        HOLD:        if (out_ready) state_next = IDLE;
        default:     state_next = IDLE;
      endcase
    end
  end

  // out_valid mirrors the registered HOLD state so the result and its valid launch together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      out_acc      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      out_valid <= (state_next == HOLD);
      if (clear) begin
        acc      <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else if (take) begin
        if (in_last) begin
          out_acc      <= sum;
          out_count    <= cnt_inc;
          out_overflow <= overflow | carry;
          acc          <= '0;
          count        <= '0;
          overflow     <= 1'b0;
        end else begin
          acc      <= sum;
          count    <= cnt_inc;
          overflow <= overflow | carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: directed frames from the block's intended use plus random frames
// scored against an arithmetic model of frame sums (MULT_ACC_SATURATE_EN selects clamp arithmetic).
module tb_product_accumulator;

  localparam int SIZE  = 16;
  localparam int PW    = 2 * SIZE;
  localparam int ACC_W = 40;
  localparam int CNT_W = 8;
  localparam int W     = ACC_W + CNT_W + 1;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [PW-1:0]    in_prod;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_overflow;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [63:0]  m_acc;
  int           m_cnt;
  logic         m_ovf;
  logic         rand_ready;
  logic         ready_req;
  logic [63:0]  acc_lim;

  product_accumulator #(
    .SIZE  (SIZE),
    .GUARD (8),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_prod      (in_prod),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_acc      (out_acc),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single owner of out_ready: random in the random phase, otherwise follows ready_req
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    else            out_ready = ready_req;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: plain running sum with an explicit 2^ACC_W limit
  task automatic model_reset();
    m_acc = 64'd0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_beat(input logic [PW-1:0] p, input logic l);
    logic [CNT_W-1:0] c;
    m_acc = m_acc + {32'd0, p};
    if (m_acc > acc_lim) begin
      m_ovf = 1'b1;
`ifdef MULT_ACC_SATURATE_EN
      m_acc = acc_lim;
`else
      m_acc = m_acc - (acc_lim + 64'd1);
`endif
    end
    m_cnt++;
    if (l) begin
      c = (m_cnt > 255) ? 8'hFF : 8'(m_cnt);
      exp_q.push_back({m_acc[ACC_W-1:0], c, m_ovf});
      model_reset();
    end
  endtask

  // driver: present one beat, wait (bounded) for in_ready, transfer on the next edge
  task automatic send_beat(input logic [PW-1:0] p, input logic l);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end else begin
      @(posedge clk);
      model_beat(p, l);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (l) check("latency_out_valid", 64'(out_valid), 64'd1);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard: every accepted result must match the head of the expected queue
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_acc", 64'(out_acc), 64'(e[W-1:CNT_W+1]));
        check("sb_count", 64'(out_count), 64'(e[CNT_W:1]));
        check("sb_overflow", 64'(out_overflow), 64'(e[0]));
      end
    end
  end

  initial begin
    int waited;
    int len;
    acc_lim    = (64'd1 << ACC_W) - 64'd1;
    rst_n      = 1'b0;
    clear      = 1'b0;
    in_valid   = 1'b0;
    in_prod    = '0;
    in_last    = 1'b0;
    out_ready  = 1'b1;
    ready_req  = 1'b1;
    rand_ready = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_acc", 64'(out_acc), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_out_overflow", 64'(out_overflow), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    idle_cycles(2);

    // three-beat frame, consumer always ready
    send_beat(32'h0006, 1'b0);
    send_beat(32'h000C, 1'b0);
    send_beat(32'h0014, 1'b1);
    check("f3_acc", 64'(out_acc), 64'h26);
    check("f3_count", 64'(out_count), 64'd3);
    check("f3_overflow", 64'(out_overflow), 64'd0);
    idle_cycles(2);

    // single beat held under backpressure
    ready_req = 1'b0;
    idle_cycles(2);
    send_beat(32'hFFFE0001, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_acc", 64'(out_acc), 64'hFFFE0001);
      check("hold_count", 64'(out_count), 64'd1);
    end
    ready_req = 1'b1;
    waited = 0;
    while (out_valid && waited < 20) begin
      @(negedge clk);
      if (out_valid) check("hs_in_ready_low", 64'(in_ready), 64'd0);
      @(posedge clk);
      #2;
      waited++;
    end
    check("after_hs_valid", 64'(out_valid), 64'd0);
    check("after_hs_in_ready", 64'(in_ready), 64'd1);
    idle_cycles(1);

    // 257 all-ones beats: count saturates, overflow set
    for (int i = 0; i < 257; i++) send_beat(32'hFFFFFFFF, (i == 256) ? 1'b1 : 1'b0);
    check("big_count", 64'(out_count), 64'hFF);
    check("big_overflow", 64'(out_overflow), 64'd1);
`ifdef MULT_ACC_SATURATE_EN
    check("big_acc", 64'(out_acc), 64'hFF_FFFF_FFFF);
`else
    check("big_acc", 64'(out_acc), 64'h00_FFFF_FEFF);
`endif
    idle_cycles(2);

    // clear with a beat offered on beat 2 of a frame
    send_beat(32'h0007, 1'b0);
    in_valid = 1'b1;
    in_prod  = 32'h0009;
    clear    = 1'b1;
    @(negedge clk);
    check("clear_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    send_beat(32'h0005, 1'b1);
    check("post_clear_acc", 64'(out_acc), 64'h5);
    check("post_clear_count", 64'(out_count), 64'd1);
    idle_cycles(2);

    // clear while holding a result: it is dropped
    ready_req = 1'b0;
    idle_cycles(2);
    send_beat(32'h1234, 1'b1);
    @(negedge clk);
    check("hold2_valid", 64'(out_valid), 64'd1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clear_hold_valid", 64'(out_valid), 64'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    ready_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("dropped_valid", 64'(out_valid), 64'd0);
    end
    idle_cycles(1);

    // asynchronous reset mid-frame
    send_beat(32'h0100, 1'b0);
    send_beat(32'h0200, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_acc", 64'(out_acc), 64'd0);
    check("arst_count", 64'(out_count), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(1);
    send_beat(32'h0007, 1'b0);
    send_beat(32'h0008, 1'b1);
    check("post_rst_acc", 64'(out_acc), 64'hF);
    check("post_rst_count", 64'(out_count), 64'd2);
    idle_cycles(2);

    // random frames with random backpressure and gaps
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        send_beat($urandom(), (b == len - 1) ? 1'b1 : 1'b0);
        if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
      end
    end
    rand_ready = 1'b0;
    ready_req  = 1'b1;
    waited = 0;
    while (exp_q.size() > 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
